// File: rtl/ex_4.sv
// ex_4: programmable 4-input boolean function held as a 16-entry truth table
//   clk      - clock, all state updates on the rising edge
//   rst      - synchronous active-high reset; loads TT_INIT into the table, clears f
//   a,b,c,d  - function inputs forming index {a,b,c,d}, a is the MSB
//   tt_we    - truth-table write enable
//   tt_wdata - new truth-table contents
//   f_comb   - combinational lookup of the current table
//   f        - registered lookup, one cycle behind the inputs
module ex_4 #(
    parameter logic [15:0] TT_INIT = 16'hF888
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a,
    input  logic        b,
    input  logic        c,
    input  logic        d,
    input  logic        tt_we,
    input  logic [15:0] tt_wdata,
    output logic        f_comb,
    output logic        f
);
    logic [3:0]  idx;
    logic [15:0] tt_q, tt_d;
    logic        f_q, f_d;
    assign idx    = {a, b, c, d};
    assign f_comb = tt_q[idx];
    assign f      = f_q;
    // f samples the pre-write table, so a write only affects f from the next edge
    always_comb begin
        tt_d = rst ? TT_INIT : (tt_we ? tt_wdata : tt_q);
        f_d  = rst ? 1'b0 : tt_q[idx];
    end
    always_ff @(posedge clk) begin
        tt_q <= tt_d;
        f_q  <= f_d;
    end
endmodule

// File: tb/tb_ex_4.sv
// tb_ex_4: scoreboard bench for ex_4 with directed scenarios and random traffic
module tb_ex_4;
    localparam logic [15:0] INIT = 16'hF888;

    typedef struct {
        logic chk;
        logic v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, a, b, c, d, tt_we;
    logic [15:0] tt_wdata;
    logic        f_comb, f;

    exp_t qc[$];
    exp_t qf[$];
    logic [15:0] tt_m;
    logic        known = 1'b0;
    int          checks = 0;
    int          errors = 0;
    bit          done = 1'b0;

    ex_4 #(.TT_INIT(INIT)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
        .tt_we(tt_we), .tt_wdata(tt_wdata), .f_comb(f_comb), .f(f)
    );

    always #5 clk = ~clk;

    // One clock of stimulus: drive at the falling edge, queue what the DUT
    // must show on f_comb before the next rising edge and on f just after it.
    task automatic step(input logic r, input logic we, input logic [15:0] wd, input logic [3:0] i);
        exp_t ec, ef;
        @(negedge clk);
        rst = r; tt_we = we; tt_wdata = wd; {a, b, c, d} = i;
        ec.chk = known;
        ec.v   = known ? tt_m[i] : 1'b0;
        ef.chk = r | known;
        ef.v   = r ? 1'b0 : (known ? tt_m[i] : 1'b0);
        qc.push_back(ec);
        qf.push_back(ef);
        if (r) begin
            tt_m  = INIT;
            known = 1'b1;
        end else if (we) begin
            tt_m = wd;
        end
    endtask

    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (qc.size() > 0) begin
            e = qc.pop_front();
            if (e.chk) begin
                checks++;
                if (f_comb !== e.v) begin
                    errors++;
                    $display("FAIL f_comb t=%0t idx=%b got=%b exp=%b", $time, {a, b, c, d}, f_comb, e.v);
                end
            end
        end
    end

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (qf.size() > 0) begin
            e = qf.pop_front();
            if (e.chk) begin
                checks++;
                if (f !== e.v) begin
                    errors++;
                    $display("FAIL f t=%0t got=%b exp=%b", $time, f, e.v);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; tt_we = 1'b0; tt_wdata = '0; {a, b, c, d} = 4'd0;
        // reset with a competing write of all zeros that must be discarded
        step(1'b1, 1'b1, 16'h0000, 4'd5);
        step(1'b1, 1'b1, 16'h0000, 4'd15);
        // default table sweep
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 16'h0, 4'(i));
        // reprogram to a single minterm at idx 0
        step(1'b0, 1'b1, 16'h0001, 4'd9);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 16'h0, 4'(i));
        // write collision at idx 15 on the default table
        step(1'b1, 1'b0, 16'h0, 4'd0);
        step(1'b0, 1'b0, 16'h0, 4'd15);
        step(1'b0, 1'b1, 16'h0000, 4'd15);
        step(1'b0, 1'b0, 16'h0, 4'd15);
        step(1'b0, 1'b0, 16'h0, 4'd15);
        // mid-operation reset restores the default table
        step(1'b0, 1'b1, 16'h0001, 4'd3);
        step(1'b0, 1'b0, 16'h0, 4'd3);
        step(1'b1, 1'b0, 16'h0, 4'd3);
        step(1'b0, 1'b0, 16'h0, 4'd3);
        step(1'b0, 1'b0, 16'h0, 4'd3);
        // random traffic
        for (int n = 0; n < 300; n++)
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 5) == 0),
                 16'($urandom), 4'($urandom_range(0, 15)));
        step(1'b0, 1'b0, 16'h0, 4'd0);
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (qc.size() != 0 || qf.size() != 0) begin
            errors++;
            $display("FAIL drain comb_left=%0d f_left=%0d exp=0", qc.size(), qf.size());
        end
        if (errors == 0) $display("Success");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
